// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
// Holds the fetch FSM state type and the default reset PC used by fetch_ctrl.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - memory and decoder handshake bundle for fetch_ctrl
// Signals:
//   mem_ren_I, mem_addr_I          fetch -> instruction memory read request
//   mem_rdata_I, mem_stall_I       instruction memory -> fetch read data / busy
//   pc_o, inst_o, inst_valid_o     fetch -> decoder held instruction
//   inst_ready_i, next_pc_i        decoder -> fetch acceptance and follow-on PC
//   redirect_i, redirect_pc_i      core -> fetch flush and restart PC
// Modports: master (the fetch controller), slave (memory + core side).
interface fetch_ctrl_if;
  logic        mem_ren_I;
  logic [31:0] mem_addr_I;
  logic [31:0] mem_rdata_I;
  logic        mem_stall_I;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] next_pc_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output mem_ren_I, mem_addr_I, pc_o, inst_o, inst_valid_o,
    input  mem_rdata_I, mem_stall_I, inst_ready_i, next_pc_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  mem_ren_I, mem_addr_I, pc_o, inst_o, inst_valid_o,
    output mem_rdata_I, mem_stall_I, inst_ready_i, next_pc_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding-read instruction fetch controller
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          fetch_ctrl_if.master (memory read port + decoder handshake)
//   stall_cnt_o  (only with FETCH_PERF_EN) cycles spent waiting on a stalled read
// Parameter RESET_PC: PC loaded while reset is asserted.
// Optional feature macro: FETCH_PERF_EN adds the stall cycle counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  stall_cnt_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pend_q, pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (bus.redirect_i) pc_d = bus.redirect_pc_i;
      end
      ST_REQ: begin
        if (bus.redirect_i) begin
          if (bus.mem_stall_I) begin
            // Read still in flight: the address must stay put until it
            // completes, so park the new target and drain.
            pend_d  = bus.redirect_pc_i;
            state_d = ST_DRAIN;
          end else begin
            pc_d = bus.redirect_pc_i;
          end
        end else if (!bus.mem_stall_I) begin
          inst_d  = bus.mem_rdata_I;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Redirect takes priority over acceptance.
        if (bus.redirect_i) begin
          pc_d    = bus.redirect_pc_i;
          state_d = ST_REQ;
        end else if (bus.inst_ready_i) begin
          pc_d    = bus.next_pc_i;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // A redirect here only replaces the parked target and keeps draining,
        // even if the old read completes in the same cycle; the next read of
        // the old address is then drained as well.
        if (bus.redirect_i) begin
          pend_d = bus.redirect_pc_i;
        end else if (!bus.mem_stall_I) begin
          pc_d    = pend_q;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_ren_I    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign bus.mem_addr_I   = pc_q;
  assign bus.pc_o         = pc_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = (state_q == ST_HOLD);

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bus.mem_ren_I && bus.mem_stall_I) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
